smg_scan_ctrl: RTL and testbench

//  Sequencer for the 4-digit seven-segment scan datapath. Accepts an 8-bit binary

---
 rtl/smg_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_smg_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/smg_scan_ctrl.sv
// Four-slot seven-segment scan sequencer: accepts an 8-bit value over valid/ready,
// converts it to BCD with a sequential double-dabble, and time-multiplexes the digits.
module smg_scan_ctrl #(
    parameter int CLK_DIV   = 25000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic [7:0] val_in,
    input  logic       val_valid,
    output logic       val_ready,
    input  logic       lz_sup,
    input  logic       dp_en,
    input  logic [1:0] dp_sel,
    output logic       busy,
    output logic [3:0] smg_en,
    output logic [3:0] Q,
    output logic       h
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_LOAD
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    bin_q, bin_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    slot_q, slot_d;
    logic [3:0]    smg_en_q, smg_en_d;
    logic [3:0]    q_q, q_d;
    logic          h_q, h_d;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [11:0] dabble_adj(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign val_ready = (state_q == ST_IDLE);
    assign busy      = !val_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        unique case (state_q)
            ST_IDLE: begin
                if (val_valid) begin
                    bin_d   = val_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_d, bin_d} = {dabble_adj(bcd_q), bin_q} << 1;
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                d1_d    = bcd_q[3:0];
                d2_d    = bcd_q[7:4];
                d3_d    = bcd_q[11:8];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic       wrap;
    logic       dp_here;
    logic       suppress;
    logic [3:0] digit;

    always_comb begin
        wrap    = (presc_q == PRESC_MAX);
        presc_d = wrap ? '0 : presc_q + 1'b1;
        slot_d  = wrap ? slot_q + 2'd1 : slot_q;

        unique case (slot_q)
            2'd0:    digit = d1_q;
            2'd1:    digit = d2_q;
            2'd2:    digit = d3_q;
            default: digit = 4'd0;
        endcase

        // A slot carrying the decimal point stays lit even if it is a leading zero.
        dp_here  = dp_en && (dp_sel == slot_q);
        suppress = lz_sup && !dp_here &&
                   (((slot_q == 2'd2) && (d3_q == 4'd0)) ||
                    ((slot_q == 2'd1) && (d3_q == 4'd0) && (d2_q == 4'd0)));

        if ((slot_q == 2'd3) || (presc_q < BLANK_END) || suppress) smg_en_d = 4'b0000;
        else                                                        smg_en_d = 4'b1000 >> slot_q;

        q_d = digit;
        h_d = dp_here && (smg_en_d != 4'b0000);
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            d3_q     <= '0;
            presc_q  <= '0;
            slot_q   <= '0;
            smg_en_q <= '0;
            q_q      <= '0;
            h_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
            state_q  <= state_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            d1_q     <= d1_d;
            d2_q     <= d2_d;
            d3_q     <= d3_d;
            presc_q  <= presc_d;
            slot_q   <= slot_d;
            smg_en_q <= smg_en_d;
            q_q      <= q_d;
            h_q      <= h_d;
        end
    end

    assign smg_en = smg_en_q;
    assign Q      = q_q;
    assign h      = h_q;

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Self-checking bench for smg_scan_ctrl: directed scenarios plus random values,
// compared every cycle against a value-level model of display and handshake.
module tb_smg_scan_ctrl;

    localparam int CLK_DIV   = 20;
    localparam int BLANK_CYC = 4;

    logic       clk_50M = 1'b0;
    logic       rst_n;
    logic [7:0] val_in;
    logic       val_valid;
    logic       val_ready;
    logic       lz_sup;
    logic       dp_en;
    logic [1:0] dp_sel;
    logic       busy;
    logic [3:0] smg_en;
    logic [3:0] Q;
    logic       h;

    smg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .val_in   (val_in),
        .val_valid(val_valid),
        .val_ready(val_ready),
        .lz_sup   (lz_sup),
        .dp_en    (dp_en),
        .dp_sel   (dp_sel),
        .busy     (busy),
        .smg_en   (smg_en),
        .Q        (Q),
        .h        (h)
    );

    always #5 clk_50M = ~clk_50M;

    int checks = 0;
    int errors = 0;

    // Model state: edges since reset release, displayed value, pending conversion.
    int m_edges;
    int m_disp;
    bit m_pend;
    int m_pend_val;
    int m_load_edge;
    bit m_accepted;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_edges    = 0;
        m_disp     = 0;
        m_pend     = 0;
        m_pend_val = 0;
        m_load_edge = 0;
        m_accepted = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_smg_en"}, 32'(smg_en), 32'd0);
        check({tag, "_Q"}, 32'(Q), 32'd0);
        check({tag, "_h"}, 32'(h), 32'd0);
        check({tag, "_val_ready"}, 32'(val_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // One clock edge: inputs seen by the edge are captured first, then outputs
    // are compared 1 time unit later against the model.
    task automatic step();
        bit lz, de, vv;
        int ds, vin, p, s, v, dig, en, hx;
        bit dph, sup;
        lz  = lz_sup;
        de  = dp_en;
        ds  = int'(dp_sel);
        vv  = val_valid;
        vin = int'(val_in);
        @(posedge clk_50M);
        #1;
        m_edges++;
        // Registered outputs show the scan position and display from before this edge.
        p = (m_edges - 1) % CLK_DIV;
        s = ((m_edges - 1) / CLK_DIV) % 4;
        v = m_disp;

        m_accepted = 0;
        if (m_pend) begin
            if (m_edges == m_load_edge) begin
                m_disp = m_pend_val;
                m_pend = 0;
            end
        end else if (vv) begin
            m_pend      = 1;
            m_pend_val  = vin;
            m_load_edge = m_edges + 9;
            m_accepted  = 1;
        end

        dig = (s == 0) ? v % 10 : (s == 1) ? (v / 10) % 10 : (s == 2) ? v / 100 : 0;
        dph = de && (ds == s);
        sup = lz && !dph && (((s == 2) && (v < 100)) || ((s == 1) && (v < 10)));
        en  = ((s == 3) || (p < BLANK_CYC) || sup) ? 0 : (8 >> s);
        hx  = (dph && (en != 0)) ? 1 : 0;

        check("smg_en", 32'(smg_en), 32'(en));
        check("Q", 32'(Q), 32'(dig));
        check("h", 32'(h), 32'(hx));
        check("val_ready", 32'(val_ready), 32'(!m_pend));
        check("busy", 32'(busy), 32'(m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present a value and hold it until the handshake completes (bounded).
    task automatic send(input int v, input bit keep_valid);
        val_in    = 8'(v);
        val_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_accepted) break;
        end
        if (!keep_valid) val_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        val_in    = '0;
        val_valid = 1'b0;
        lz_sup    = 1'b0;
        dp_en     = 1'b0;
        dp_sel    = 2'd3;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(negedge clk_50M);
        rst_n = 1'b1;

        // Idle scan after reset: blank window, then 0s in slots 0..2, slot 3 dark.
        run(4 * CLK_DIV + 5);

        // 173 -> 3/7/1.
        send(173, 0);
        run(4 * CLK_DIV + 12);

        // Leading-zero suppression.
        lz_sup = 1'b1;
        send(5, 0);
        run(4 * CLK_DIV + 12);
        send(40, 0);
        run(4 * CLK_DIV + 12);
        lz_sup = 1'b0;

        // Back-to-back with val_valid held high throughout.
        send(255, 1);
        val_in = 8'd0;
        send(0, 0);
        run(4 * CLK_DIV + 12);

        // Decimal point on slot 1, then overriding suppression.
        dp_en  = 1'b1;
        dp_sel = 2'd1;
        send(12, 0);
        run(4 * CLK_DIV + 12);
        lz_sup = 1'b1;
        send(2, 0);
        run(4 * CLK_DIV + 12);
        lz_sup = 1'b0;
        dp_en  = 1'b0;
        dp_sel = 2'd3;

        // Reset in the middle of a conversion of 200.
        send(200, 0);
        run(4);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk_50M);
        rst_n = 1'b1;
        run(4 * CLK_DIV + 2);
        send(9, 0);
        run(4 * CLK_DIV + 12);

        // Random values and display controls, including changes mid-scan.
        for (int k = 0; k < 14; k++) begin
            lz_sup = 1'($urandom_range(0, 1));
            dp_en  = 1'($urandom_range(0, 1));
            dp_sel = 2'($urandom_range(0, 3));
            send(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            val_valid = 1'b0;
            run(int'($urandom_range(0, 30)));
            lz_sup = 1'($urandom_range(0, 1));
            run(int'($urandom_range(10, 90)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
